switch_debouncer: RTL and testbench

//  Conditions a raw mechanical switch input before it reaches LED control logic.

---
 rtl/switch_io_pkg.sv | 18 +
 rtl/signal_synchronizer.sv | 20 ++
 rtl/switch_debouncer.sv | 117 +++++++++++
 tb/tb_switch_debouncer.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/switch_io_pkg.sv
// Shared types and helpers for the switch input conditioning path.
// Holds the debounce FSM encoding and the ms-to-cycles conversion.
package switch_io_pkg;

  typedef enum logic [1:0] {
    ST_LOW,
    ST_WAIT_HI,
    ST_HIGH,
    ST_WAIT_LO
  } db_state_t;

  localparam int DEFAULT_CLK_HZ = 50_000_000;

  function automatic int db_cycles(input int clk_hz, input int ms);
    return clk_hz / 1000 * ms;
  endfunction

endpackage

// File: rtl/signal_synchronizer.sv
// N-flop synchronizer chain for a single asynchronous bit; q lags d by STAGES cycles.
module signal_synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) chain <= '0;
    else     chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/switch_debouncer.sv
// Switch debouncer: synchronizer + hold-off FSM, clean level and registered rise/fall strobes.
// Optional latching toggle output enabled by SWITCH_DEBOUNCER_TOGGLE_EN (otherwise toggle_q is 0).
module switch_debouncer
  import switch_io_pkg::*;
#(
  parameter int CLK_HZ      = DEFAULT_CLK_HZ,
  parameter int DEBOUNCE_MS = 10,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_raw,
  output logic sw_clean,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic toggle_q
);

  localparam int DB_CYCLES = db_cycles(CLK_HZ, DEBOUNCE_MS);
  localparam int CNT_W     = $clog2(DB_CYCLES);
  // Commit on the cycle the counter steps onto DB_CYCLES-1, so the first stable
  // sample counts as cycle zero and end-to-end latency is SYNC_STAGES + DB_CYCLES.
  localparam logic [CNT_W-1:0] CNT_COMMIT = CNT_W'(DB_CYCLES - 2);

  if (DB_CYCLES < 2) begin : g_bad_db
    $error("switch_debouncer: DB_CYCLES must be >= 2");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("switch_debouncer: SYNC_STAGES must be >= 2");
  end

  logic             sw_s;
  db_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             clean_nxt, rise_nxt, fall_nxt;

  signal_synchronizer #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (sw_raw),
    .q   (sw_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_LOW;
      cnt        <= '0;
      sw_clean   <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      sw_clean   <= clean_nxt;
      rise_pulse <= rise_nxt;
      fall_pulse <= fall_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    clean_nxt = sw_clean;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    case (state)
      ST_LOW: begin
        if (sw_s) begin
          state_nxt = ST_WAIT_HI;
          cnt_nxt   = '0;
        end
      end
      ST_WAIT_HI: begin
        if (!sw_s) begin
          state_nxt = ST_LOW;
        end else begin
          // Counter tops out at DB_CYCLES-1 and leaves the wait state there, so it never wraps.
          cnt_nxt = cnt + 1'b1;
          if (cnt >= CNT_COMMIT) begin
            state_nxt = ST_HIGH;
            clean_nxt = 1'b1;
            rise_nxt  = 1'b1;
          end
        end
      end
      ST_HIGH: begin
        if (!sw_s) begin
          state_nxt = ST_WAIT_LO;
          cnt_nxt   = '0;
        end
      end
      ST_WAIT_LO: begin
        if (sw_s) begin
          state_nxt = ST_HIGH;
        end else begin
          cnt_nxt = cnt + 1'b1;
          if (cnt >= CNT_COMMIT) begin
            state_nxt = ST_LOW;
            clean_nxt = 1'b0;
            fall_nxt  = 1'b1;
          end
        end
      end
      default: state_nxt = ST_LOW;
    endcase
  end

`ifdef SWITCH_DEBOUNCER_TOGGLE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             toggle_q <= 1'b0;
    else if (rise_pulse) toggle_q <= ~toggle_q;
  end
`else
  assign toggle_q = 1'b0;
`endif

endmodule

// File: tb/tb_switch_debouncer.sv
// Scoreboard bench for switch_debouncer: expected strobes are queued with their due cycle
// when sw_raw/rst is driven and matched against the strobes the DUT produces.
module tb_switch_debouncer;

  localparam int CLK_HZ      = 1000;
  localparam int DEBOUNCE_MS = 5;
  localparam int SYNC_STAGES = 2;
  localparam int DB_CYCLES   = CLK_HZ / 1000 * DEBOUNCE_MS;
  localparam int LAT         = SYNC_STAGES + DB_CYCLES;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sw_raw = 1'b1;
  logic sw_clean, rise_pulse, fall_pulse, toggle_q;

  typedef struct packed {
    logic        is_rise;
    logic [31:0] cyc;
  } ev_t;

  ev_t  sb[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  logic exp_tog = 1'b0;

  switch_debouncer #(
    .CLK_HZ      (CLK_HZ),
    .DEBOUNCE_MS (DEBOUNCE_MS),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sw_raw     (sw_raw),
    .sw_clean   (sw_clean),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .toggle_q   (toggle_q)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    else n_pass++;
  endtask

  // Every strobe the DUT emits must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && (rise_pulse || fall_pulse)) begin
      ev_t e;
      chk("pulse_exclusive", 32'(rise_pulse & fall_pulse), 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_pulse", 32'(rise_pulse), 32'(1'b0));
        chk("unexpected_pulse", 32'(fall_pulse), 32'(1'b0));
      end else begin
        e = sb.pop_front();
        chk("pulse_kind",  32'(rise_pulse), 32'(e.is_rise));
        chk("pulse_cycle", 32'(cyc),        e.cyc);
        chk("clean_level", 32'(sw_clean),   32'(e.is_rise));
      end
    end
  end

  task automatic expect_edge(input logic is_rise);
    sb.push_back('{is_rise: is_rise, cyc: 32'(cyc + LAT)});
`ifdef SWITCH_DEBOUNCER_TOGGLE_EN
    if (is_rise) exp_tog = ~exp_tog;
`endif
  endtask

  task automatic set_raw(input logic v);
    @(posedge clk);
    #1 sw_raw = v;
  endtask

  task automatic drain(input string tag, input logic level);
    for (int i = 0; i < 4 * LAT && sb.size() != 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk({tag, "_drain"}, 32'(sb.size()), 32'd0);
    chk({tag, "_level"}, 32'(sw_clean), 32'(level));
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge clk);
    chk({tag, "_clean"},  32'(sw_clean),   32'd0);
    chk({tag, "_rise"},   32'(rise_pulse), 32'd0);
    chk({tag, "_fall"},   32'(fall_pulse), 32'd0);
    chk({tag, "_toggle"}, 32'(toggle_q),   32'd0);
  endtask

  task automatic release_rst();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    // Reset held with the switch already pressed, then qualification after release.
    repeat (3) @(posedge clk);
    check_reset_outputs("rst_hold");
    release_rst();
    expect_edge(1'b1);
    drain("rst_release", 1'b1);

    // Clean release, then clean press.
    set_raw(1'b0);
    expect_edge(1'b0);
    drain("release", 1'b0);
    set_raw(1'b1);
    expect_edge(1'b1);
    drain("press", 1'b1);
    set_raw(1'b0);
    expect_edge(1'b0);
    drain("release2", 1'b0);

    // Bounce: high 3, low 1, then steady high; only the last edge qualifies.
    set_raw(1'b1);
    repeat (2) @(posedge clk);
    set_raw(1'b0);
    set_raw(1'b1);
    expect_edge(1'b1);
    drain("bounce", 1'b1);
    set_raw(1'b0);
    expect_edge(1'b0);
    drain("release3", 1'b0);

    // Reset while the counter sits at 3 in ST_WAIT_HI.
    set_raw(1'b1);
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    exp_tog = 1'b0;
    check_reset_outputs("rst_mid");
    @(posedge clk);
    check_reset_outputs("rst_mid2");
    release_rst();
    expect_edge(1'b1);
    drain("requalify", 1'b1);
    set_raw(1'b0);
    expect_edge(1'b0);
    drain("release4", 1'b0);

    // Input toggling every cycle never qualifies.
    for (int i = 0; i < 40; i++) set_raw(~sw_raw);
    drain("chatter", 1'b0);

    // Three clean presses drive the toggle latch.
    @(posedge clk);
    #1 rst = 1'b1;
    exp_tog = 1'b0;
    check_reset_outputs("rst_tog");
    release_rst();
    for (int p = 0; p < 3; p++) begin
      set_raw(1'b1);
      expect_edge(1'b1);
      drain("tog_press", 1'b1);
      chk("toggle_q", 32'(toggle_q), 32'(exp_tog));
      set_raw(1'b0);
      expect_edge(1'b0);
      drain("tog_release", 1'b0);
      chk("toggle_hold", 32'(toggle_q), 32'(exp_tog));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
